// File: rtl/hadamard_tx_stream.sv
// Hadamard-coded PAM transmit stream: packs H-1 PAM symbols plus a zero pilot,
// runs an in-place radix-2 Walsh-Hadamard transform and emits min-shifted chips.

module hadamard_tx_lane #(
   parameter int MIDLE_BITS = 8,
   parameter int BIT_NUM    = 4
) (
   input  logic [MIDLE_BITS-1:0] a_i,
   input  logic [MIDLE_BITS-1:0] b_i,
   input  logic [MIDLE_BITS-1:0] off_i,
   input  logic [MIDLE_BITS-1:0] min_i,
   input  logic                  upper_i,
   output logic [MIDLE_BITS-1:0] bfly_o,
   output logic [BIT_NUM-1:0]    chip_o,
   output logic                  ovf_o
);
   localparam int ZW = ((MIDLE_BITS > BIT_NUM) ? MIDLE_BITS : BIT_NUM) + 1;
   localparam logic [ZW-1:0] CHIP_MAX = ZW'((64'd1 << BIT_NUM) - 64'd1);

   logic [MIDLE_BITS-1:0] z;
   logic [ZW-1:0]         z_ext;

   // Upper element of a pair takes (partner - self); two's complement wraps
   // identically for signed and unsigned, so plain adders suffice.
   assign bfly_o = (upper_i ? (b_i - a_i) : (a_i + b_i)) + off_i;
   assign z      = a_i - min_i;
   assign z_ext  = ZW'(z);
   assign chip_o = z_ext[BIT_NUM-1:0];
   assign ovf_o  = z_ext > CHIP_MAX;
endmodule

module hadamard_tx_stream #(
   parameter int PAM_LEVEL_LOG = 2,
   parameter int HADAMARD      = 4,
   parameter int BIT_NUM       = 4,
   parameter int MIDLE_BITS    = 8,
   localparam int IN_BITS  = PAM_LEVEL_LOG * (HADAMARD - 1),
   localparam int OUT_BITS = HADAMARD * BIT_NUM,
   localparam int LOG_H    = $clog2(HADAMARD)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [IN_BITS-1:0]  s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [OUT_BITS-1:0] m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_ovf
);
   localparam int H = HADAMARD;
   localparam int P = PAM_LEVEL_LOG;
   localparam logic [LOG_H-1:0] LAST_STG = LOG_H'(LOG_H - 1);

   typedef enum logic [2:0] {IDLE, XFORM, MINF, NORM, HOLD} state_t;

   state_t                       state_q, state_d;
   logic [LOG_H-1:0]             stage_q, stride;
   logic [H-1:0][MIDLE_BITS-1:0] y_q, y_load, y_bfly;
   logic [MIDLE_BITS-1:0]        m_q, min_w;
   logic [OUT_BITS-1:0]          m_data_q;
   logic                         m_ovf_q, m_valid_q, m_valid_d;
   logic [H-1:0][BIT_NUM-1:0]    chips_w;
   logic [H-1:0]                 ovf_w;
   logic                         s_ready_w, last_stg;
   logic                         ld_en, stg_en, min_en, norm_en;

   assign last_stg = (stage_q == LAST_STG);
   assign stride   = LOG_H'(1) << stage_q;

   for (genvar i = 0; i < H; i++) begin : g_lane
      logic [LOG_H-1:0]      idx, pidx;
      logic [MIDLE_BITS-1:0] off;

      assign idx  = LOG_H'(i);
      assign pidx = idx ^ stride;

      // Element 0 carries the pilot d[H-1] and gets no offset.
      if (i == 0) begin : g_pilot
         assign y_load[i] = '0;
         assign off       = '0;
      end else begin : g_sym
         assign y_load[i] = MIDLE_BITS'(s_data[(H-1-i)*P +: P]);
         assign off       = last_stg ? MIDLE_BITS'(H / 2) : '0;
      end

      hadamard_tx_lane #(
         .MIDLE_BITS (MIDLE_BITS),
         .BIT_NUM    (BIT_NUM)
      ) u_lane (
         .a_i     (y_q[i]),
         .b_i     (y_q[pidx]),
         .off_i   (off),
         .min_i   (m_q),
         .upper_i (|(idx & stride)),
         .bfly_o  (y_bfly[i]),
         .chip_o  (chips_w[H-1-i]),
         .ovf_o   (ovf_w[i])
      );
   end

   always_comb begin
      min_w = y_q[0];
      for (int i = 1; i < H; i++)
         if ($signed(y_q[i]) < $signed(min_w)) min_w = y_q[i];
   end

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      s_ready_w = 1'b0;
      ld_en     = 1'b0;
      stg_en    = 1'b0;
      min_en    = 1'b0;
      norm_en   = 1'b0;
      m_valid_d = m_valid_q;
      case (state_q)
         IDLE: begin
            s_ready_w = 1'b1;
            if (s_valid) begin
               ld_en   = 1'b1;
               state_d = XFORM;
            end
         end
         XFORM: begin
            stg_en = 1'b1;
            if (last_stg) state_d = MINF;
         end
         MINF: begin
            min_en  = 1'b1;
            state_d = NORM;
         end
         NORM: begin
            norm_en   = 1'b1;
            m_valid_d = 1'b1;
            state_d   = HOLD;
         end
         HOLD: begin
            // Accepting in the same cycle as the handoff keeps one word per LOG_H+3.
            if (m_ready) begin
               s_ready_w = 1'b1;
               m_valid_d = 1'b0;
               if (s_valid) begin
                  ld_en   = 1'b1;
                  state_d = XFORM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         y_q       <= '0;
         stage_q   <= '0;
         m_q       <= '0;
         m_data_q  <= '0;
         m_ovf_q   <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         m_valid_q <= m_valid_d;
         if (ld_en)       y_q <= y_load;
         else if (stg_en) y_q <= y_bfly;
         if (stg_en) stage_q <= last_stg ? '0 : stage_q + LOG_H'(1);
         if (min_en) m_q <= min_w;
         if (norm_en) begin
            m_data_q <= chips_w;
            m_ovf_q  <= |ovf_w;
         end
      end
   end

   assign s_ready = s_ready_w & resetn;
   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign m_ovf   = m_ovf_q;
endmodule
